// File: rtl/payload_reader.sv
// payload_reader: egress engine for the read side of the payload buffer.
// Accepts a descriptor (head block address, destructive flag), walks the block
// chain with one read per clock, and streams the returned words through a
// 2-entry output FIFO on a valid/ready interface with first/last/error markers.
//
// Ports
//   clock, reset_n          single clock, asynchronous active-low reset
//   desc_valid/desc_ready   descriptor handshake; desc_address, desc_destructive
//   buf_ready               buffer initialised; reads stall while low
//   rd_enable, rd_first     read strobe; rd_first selects rd_address over nextPtr
//   rd_address              head block address (valid with rd_first)
//   rd_destructive          destructive-read qualifier for the current packet
//   rd_data, rd_last        buffer response, valid the clock after rd_enable
//   out_valid/out_ready     output stream handshake
//   out_data, out_first, out_last, out_error   stream word and markers
module payload_reader #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BUFFER_SIZE = 2048,
    parameter int unsigned MAX_WORDS   = 512
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           desc_valid,
    output logic                           desc_ready,
    input  logic [$clog2(BUFFER_SIZE)-1:0] desc_address,
    input  logic                           desc_destructive,
    input  logic                           buf_ready,
    output logic                           rd_enable,
    output logic                           rd_first,
    output logic [$clog2(BUFFER_SIZE)-1:0] rd_address,
    output logic                           rd_destructive,
    input  logic [DATA_WIDTH-1:0]          rd_data,
    input  logic                           rd_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_first,
    output logic                           out_last,
    output logic                           out_error
);

    localparam int unsigned AW = $clog2(BUFFER_SIZE);
    localparam int unsigned CW = $clog2(MAX_WORDS + 1);
    localparam int unsigned EW = DATA_WIDTH + 3;

    typedef enum logic [1:0] {IDLE, FIRST, STREAM, DRAIN} state_t;

    state_t          state;
    state_t          state_next;
    logic            alive;
    logic [AW-1:0]   addr_q;
    logic            destr_q;
    logic            inflight;
    logic [CW-1:0]   word_cnt;
    logic [EW-1:0]   mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      fcount;

    logic            pop;
    logic            push;
    logic            issue_ok;
    logic            at_limit;
    logic            end_of_chain;
    logic [2:0]      occupancy;
    logic [EW-1:0]   entry;
    logic [EW-1:0]   head;

    // A read returns exactly one clock after issue, so inflight marks the return cycle.
    assign pop          = out_valid & out_ready;
    assign push         = inflight;
    assign occupancy    = 3'(fcount) + 3'(inflight) - 3'(pop);
    assign issue_ok     = occupancy < 3'd2;
    assign at_limit     = word_cnt == CW'(MAX_WORDS - 1);
    assign end_of_chain = inflight & (rd_last | at_limit);
    assign entry        = {rd_data, word_cnt == '0, rd_last | at_limit, ~rd_last & at_limit};
    assign head         = mem[rd_ptr];

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (desc_valid && desc_ready) state_next = FIRST;
            FIRST:  if (rd_enable) state_next = STREAM;
            STREAM: if (end_of_chain) state_next = DRAIN;
            DRAIN:  if (fcount == 2'd0 || (fcount == 2'd1 && pop)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic; alive keeps desc_ready low while reset is held.
    always_comb begin
        desc_ready     = 1'b0;
        rd_enable      = 1'b0;
        rd_first       = 1'b0;
        rd_destructive = 1'b0;
        case (state)
            IDLE: begin
                desc_ready = alive & buf_ready & (fcount == 2'd0);
            end
            FIRST: begin
                rd_enable      = buf_ready & issue_ok;
                rd_first       = buf_ready & issue_ok;
                rd_destructive = destr_q;
            end
            STREAM: begin
                rd_enable      = buf_ready & issue_ok & ~end_of_chain;
                rd_destructive = destr_q;
            end
            default: ;
        endcase
        rd_address = rd_first ? addr_q : '0;
    end

    // Stream outputs come straight from the FIFO head, blanked when empty.
    always_comb begin
        out_valid = fcount != 2'd0;
        out_data  = out_valid ? head[EW-1:3] : '0;
        out_first = out_valid & head[2];
        out_last  = out_valid & head[1];
        out_error = out_valid & head[0];
    end

    // Descriptor latch, read tracking and saturating word counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alive    <= 1'b0;
            addr_q   <= '0;
            destr_q  <= 1'b0;
            inflight <= 1'b0;
            word_cnt <= '0;
        end else begin
            alive    <= 1'b1;
            inflight <= rd_enable;
            if (desc_valid && desc_ready) begin
                addr_q   <= desc_address;
                destr_q  <= desc_destructive;
                word_cnt <= '0;
            end else if (push && word_cnt != CW'(MAX_WORDS)) begin
                word_cnt <= word_cnt + CW'(1);
            end
        end
    end

    // 2-entry output FIFO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            fcount <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fcount <= fcount + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_payload_reader.sv
// Bench for payload_reader: a behavioural buffer model answers reads, a reference
// model predicts each packet's words into a queue, and a monitor pops and compares.
module tb_payload_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned BS = 2048;
    localparam int unsigned MW = 8;
    localparam int unsigned AW = $clog2(BS);

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           desc_valid = 1'b0;
    logic           desc_ready;
    logic [AW-1:0]  desc_address = '0;
    logic           desc_destructive = 1'b0;
    logic           buf_ready = 1'b0;
    logic           rd_enable;
    logic           rd_first;
    logic [AW-1:0]  rd_address;
    logic           rd_destructive;
    logic [DW-1:0]  rd_data = '0;
    logic           rd_last = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [DW-1:0]  out_data;
    logic           out_first;
    logic           out_last;
    logic           out_error;

    payload_reader #(.DATA_WIDTH(DW), .BUFFER_SIZE(BS), .MAX_WORDS(MW)) dut (
        .clock(clock), .reset_n(reset_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_address(desc_address), .desc_destructive(desc_destructive),
        .buf_ready(buf_ready),
        .rd_enable(rd_enable), .rd_first(rd_first), .rd_address(rd_address),
        .rd_destructive(rd_destructive), .rd_data(rd_data), .rd_last(rd_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_last(out_last), .out_error(out_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          first;
        logic          last;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] chain_data [16];
    logic          chain_last [16];
    logic [AW-1:0] cur_head = '0;
    logic          cur_destr = 1'b0;
    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            reads_total = 0;
    int            held = 0;
    logic          inflight_tb = 1'b0;
    int            bpos = 0;
    int            rd_first_cyc = 0;
    int            rd_last_cyc = 0;
    int            pop_first_cyc = 0;
    int            pop_last_cyc = 0;
    int            ready_mode = 0;
    int            buf_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Buffer model: answers each read one clock later and audits the read side.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            held        <= 0;
            inflight_tb <= 1'b0;
        end else begin
            int   p;
            logic pop_now;
            pop_now = out_valid & out_ready;
            cyc <= cyc + 1;
            if (rd_enable) begin
                chk("rd_buf_ready", 64'(buf_ready), 64'd1);
                chk("rd_issue_rule", 64'((held + int'(inflight_tb) - int'(pop_now)) < 2), 64'd1);
                chk("rd_destructive", 64'(rd_destructive), 64'(cur_destr));
                if (rd_first) begin
                    chk("rd_address", 64'(rd_address), 64'(cur_head));
                    p = 0;
                    rd_first_cyc <= cyc;
                end else begin
                    p = bpos + 1;
                end
                if (p > 15) p = 15;
                bpos        <= p;
                rd_data     <= chain_data[p];
                rd_last     <= chain_last[p];
                reads_total <= reads_total + 1;
                rd_last_cyc <= cyc;
            end
            held        <= held + int'(inflight_tb) - int'(pop_now);
            inflight_tb <= rd_enable;
        end
    end

    // Monitor: every accepted output word is checked against the predicted queue.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("out_first", 64'(out_first), 64'(e.first));
                chk("out_last", 64'(out_last), 64'(e.last));
                chk("out_error", 64'(out_error), 64'(e.err));
            end
            if (out_first) pop_first_cyc = cyc;
            if (out_last) pop_last_cyc = cyc;
        end
    end

    // Downstream readiness and buffer readiness patterns.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            case (buf_mode)
                0:       buf_ready = 1'b1;
                1:       buf_ready = ($urandom_range(0, 4) != 0);
                default: buf_ready = 1'b0;
            endcase
        end
    end

    // Build a chain and predict its words: a terminated chain of at most MW blocks
    // yields all its words; anything longer or unterminated is cut at MW with error.
    task automatic setup_pkt(input int len, input bit term, input bit destr, output int n);
        bit   err;
        exp_t e;
        n   = (term && len <= MW) ? len : MW;
        err = !(term && len <= MW);
        for (int i = 0; i < 16; i++) begin
            chain_data[i] = $urandom;
            chain_last[i] = term && (i == len - 1);
        end
        cur_head  = AW'($urandom);
        cur_destr = destr;
        for (int i = 0; i < n; i++) begin
            e.data  = chain_data[i];
            e.first = (i == 0);
            e.last  = (i == n - 1);
            e.err   = err && (i == n - 1);
            exp_q.push_back(e);
        end
        desc_address     = cur_head;
        desc_destructive = destr;
    endtask

    task automatic offer_desc(output bit ok);
        ok = 1'b0;
        desc_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (desc_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
        desc_valid = 1'b0;
        chk("desc_accept", 64'(ok), 64'd1);
    endtask

    // mode 1: check back-to-back reads and pops; mode 2: check desc_ready after final pop.
    task automatic run_pkt(input int len, input bit term, input bit destr, input int mode);
        int n;
        int r0;
        bit ok;
        bit seen;
        setup_pkt(len, term, destr, n);
        r0 = reads_total;
        offer_desc(ok);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        if (mode == 2) begin
            seen = 1'b0;
            for (int k = 0; k < 300; k++) begin
                @(negedge clock);
                if (out_valid && out_ready && out_last) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("last_pop_seen", 64'(seen), 64'd1);
            chk("desc_ready_at_pop", 64'(desc_ready), 64'd0);
            @(negedge clock);
            chk("desc_ready_after_pop", 64'(desc_ready), 64'd1);
        end
        for (int k = 0; k < 2000; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock);
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        chk("read_count", 64'(reads_total - r0), 64'(n));
        if (mode == 1) begin
            chk("rd_span", 64'(rd_last_cyc - rd_first_cyc), 64'(n - 1));
            chk("pop_span", 64'(pop_last_cyc - pop_first_cyc), 64'(n - 1));
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        bit ok;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", 64'({desc_ready, rd_enable, rd_first, rd_address, rd_destructive,
                                  out_valid, out_data, out_first, out_last, out_error}), 64'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        run_pkt(4, 1'b1, 1'b0, 1);      // contiguous 4-word chain
        ready_mode = 1;
        run_pkt(4, 1'b1, 1'b1, 0);      // toggling out_ready
        ready_mode = 0;
        run_pkt(1, 1'b1, 1'b0, 2);      // single-block packet
        run_pkt(16, 1'b0, 1'b1, 0);     // unterminated chain, truncated
        run_pkt(8, 1'b1, 1'b0, 0);      // exactly MW words, clean end
        run_pkt(9, 1'b1, 1'b1, 0);      // one past MW, truncated

        // Buffer not ready: descriptor must not be accepted.
        buf_mode = 2;
        repeat (2) @(posedge clock);
        #1;
        desc_valid = 1'b1;
        @(negedge clock);
        chk("desc_ready_no_buf", 64'(desc_ready), 64'd0);
        @(posedge clock);
        #1;
        desc_valid = 1'b0;
        buf_mode = 0;
        repeat (2) @(posedge clock);
        #1;

        // Reset in the middle of a packet.
        setup_pkt(8, 1'b1, 1'b1, n);
        offer_desc(ok);
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_outputs", 64'({desc_ready, rd_enable, rd_first, rd_address, rd_destructive,
                                     out_valid, out_data, out_first, out_last, out_error}), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        run_pkt(5, 1'b1, 1'b0, 0);

        // Randomised packets under random readiness.
        for (int k = 0; k < 30; k++) begin
            ready_mode = $urandom_range(0, 2);
            buf_mode   = $urandom_range(0, 1);
            run_pkt($urandom_range(1, 12), ($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
